// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory arbiter: FSM states, requester ids
// and the fault codes returned with each completion.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_e;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DBG  = 1'b1
  } req_id_e;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_MEM     = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/bus_watchdog.sv
// Clear/enable cycle counter that flags when a transaction has waited TIMEOUT cycles.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the core and a debug/DMA requester with
// round-robin tie breaking and a watchdog that aborts unacknowledged accesses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        core_req,
  input  logic        core_write,
  input  logic [1:0]  core_size,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_done,
  output logic [31:0] core_rdata,
  output logic [1:0]  core_fault,
  input  logic        dbg_req,
  input  logic        dbg_write,
  input  logic [1:0]  dbg_size,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_done,
  output logic [31:0] dbg_rdata,
  output logic [1:0]  dbg_fault,
  output logic        mem_req,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  arb_state_e  state;
  req_id_e     grant;
  req_id_e     last_grant;
  req_id_e     pick;
  logic        wd_expired;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_fault;

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state == IDLE),
    .enable  ((state == BUSY) && !mem_ack),
    .expired (wd_expired)
  );

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    pick = REQ_CORE;
    if (core_req && dbg_req) begin
      pick = (last_grant == REQ_DBG) ? REQ_CORE : REQ_DBG;
    end else if (dbg_req) begin
      pick = REQ_DBG;
    end
  end

  // An ack in the expiry cycle still counts as a normal completion.
  always_comb begin
    resp_rdata = '0;
    resp_fault = FAULT_TIMEOUT;
    if (mem_ack) begin
      resp_rdata = mem_rdata;
      resp_fault = mem_err ? FAULT_MEM : FAULT_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= REQ_CORE;
      last_grant <= REQ_DBG;
      core_done  <= 1'b0;
      core_rdata <= '0;
      core_fault <= FAULT_NONE;
      dbg_done   <= 1'b0;
      dbg_rdata  <= '0;
      dbg_fault  <= FAULT_NONE;
      mem_req    <= 1'b0;
      mem_write  <= 1'b0;
      mem_size   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      core_done <= 1'b0;
      dbg_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (core_req || dbg_req) begin
            grant   <= pick;
            mem_req <= 1'b1;
            state   <= BUSY;
            if (pick == REQ_DBG) begin
              mem_write <= dbg_write;
              mem_size  <= dbg_size;
              mem_addr  <= dbg_addr;
              mem_wdata <= dbg_wdata;
            end else begin
              mem_write <= core_write;
              mem_size  <= core_size;
              mem_addr  <= core_addr;
              mem_wdata <= core_wdata;
            end
          end
        end
        BUSY: begin
          if (mem_ack || wd_expired) begin
            mem_req <= 1'b0;
            state   <= RESP;
            // done is raised on entry so it is visible during the RESP cycle
            if (grant == REQ_DBG) begin
              dbg_done  <= 1'b1;
              dbg_rdata <= resp_rdata;
              dbg_fault <= resp_fault;
            end else begin
              core_done  <= 1'b1;
              core_rdata <= resp_rdata;
              core_fault <= resp_fault;
            end
          end
        end
        RESP: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a short watchdog (TIMEOUT=4).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_req, core_write;
  logic [1:0]  core_size;
  logic [31:0] core_addr, core_wdata;
  logic        core_done;
  logic [31:0] core_rdata;
  logic [1:0]  core_fault;
  logic        dbg_req, dbg_write;
  logic [1:0]  dbg_size;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_done;
  logic [31:0] dbg_rdata;
  logic [1:0]  dbg_fault;
  logic        mem_req, mem_write;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .core_req   (core_req),
    .core_write (core_write),
    .core_size  (core_size),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_done  (core_done),
    .core_rdata (core_rdata),
    .core_fault (core_fault),
    .dbg_req    (dbg_req),
    .dbg_write  (dbg_write),
    .dbg_size   (dbg_size),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_done   (dbg_done),
    .dbg_rdata  (dbg_rdata),
    .dbg_fault  (dbg_fault),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .mem_size   (mem_size),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    core_req = 1'b0; core_write = 1'b0; core_size = 2'd0; core_addr = '0; core_wdata = '0;
    dbg_req = 1'b0; dbg_write = 1'b0; dbg_size = 2'd0; dbg_addr = '0; dbg_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    step();
    step();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_core_done", 32'(core_done), 32'd0);
    check("rst_dbg_done", 32'(dbg_done), 32'd0);
    check("rst_core_rdata", core_rdata, 32'd0);
    check("rst_core_fault", 32'(core_fault), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    reset_n = 1'b1;

    // Tie after reset: core, then dbg, then core again.
    core_req = 1'b1; core_write = 1'b1; core_size = 2'd2; core_addr = 32'h200; core_wdata = 32'h1111_1111;
    dbg_req = 1'b1; dbg_write = 1'b0; dbg_size = 2'd1; dbg_addr = 32'h300; dbg_wdata = 32'h2222_2222;
    step();
    check("tie1_mem_req", 32'(mem_req), 32'd1);
    check("tie1_mem_addr", mem_addr, 32'h200);
    check("tie1_mem_write", 32'(mem_write), 32'd1);
    check("tie1_mem_wdata", mem_wdata, 32'h1111_1111);
    mem_ack = 1'b1; mem_rdata = 32'h0;
    step();
    mem_ack = 1'b0;
    check("tie1_core_done", 32'(core_done), 32'd1);
    check("tie1_dbg_done", 32'(dbg_done), 32'd0);
    check("tie1_mem_req_resp", 32'(mem_req), 32'd0);
    step();
    check("tie1_idle_done", 32'(core_done), 32'd0);
    step();
    check("tie2_mem_addr", mem_addr, 32'h300);
    check("tie2_mem_write", 32'(mem_write), 32'd0);
    check("tie2_mem_size", 32'(mem_size), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_ack = 1'b0;
    check("tie2_dbg_done", 32'(dbg_done), 32'd1);
    check("tie2_dbg_rdata", dbg_rdata, 32'hCAFE_F00D);
    check("tie2_core_done", 32'(core_done), 32'd0);
    step();
    step();
    check("tie3_mem_addr", mem_addr, 32'h200);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0042;
    step();
    mem_ack = 1'b0;
    check("tie3_core_done", 32'(core_done), 32'd1);
    check("tie3_core_rdata", core_rdata, 32'h0000_0042);
    core_req = 1'b0; dbg_req = 1'b0;
    step();

    // mem_err with ack on a dbg-only request.
    dbg_req = 1'b1; dbg_write = 1'b0; dbg_size = 2'd2; dbg_addr = 32'h404;
    step();
    check("err_mem_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_err = 1'b1; mem_rdata = 32'h55;
    step();
    mem_ack = 1'b0; mem_err = 1'b0; dbg_req = 1'b0;
    check("err_dbg_done", 32'(dbg_done), 32'd1);
    check("err_dbg_fault", 32'(dbg_fault), 32'd1);
    check("err_core_fault_hold", 32'(core_fault), 32'd0);
    check("err_core_rdata_hold", core_rdata, 32'h0000_0042);
    step();

    // Timeout: no ack, done with fault 10 in cycle 5.
    core_req = 1'b1; core_write = 1'b0; core_size = 2'd2; core_addr = 32'h500;
    step();
    check("to_mem_req_c1", 32'(mem_req), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      step();
      check("to_mem_req_wait", 32'(mem_req), 32'd1);
      check("to_done_wait", 32'(core_done), 32'd0);
    end
    step();
    check("to_core_done", 32'(core_done), 32'd1);
    check("to_core_fault", 32'(core_fault), 32'd2);
    check("to_core_rdata", core_rdata, 32'd0);
    check("to_mem_req_resp", 32'(mem_req), 32'd0);
    core_req = 1'b0;
    mem_ack = 1'b1; mem_err = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    step();
    check("stray_ack_done", 32'(core_done), 32'd0);
    check("stray_ack_dbg_done", 32'(dbg_done), 32'd0);
    step();
    check("stray_ack_mem_req", 32'(mem_req), 32'd0);
    check("stray_ack_fault_hold", 32'(core_fault), 32'd2);
    mem_ack = 1'b0; mem_err = 1'b0;

    // Ack in the same cycle the watchdog expires: ack wins.
    dbg_req = 1'b1; dbg_addr = 32'h600;
    step();
    step();
    step();
    step();
    check("ackto_no_done_yet", 32'(dbg_done), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 1'b0; dbg_req = 1'b0;
    check("ackto_dbg_done", 32'(dbg_done), 32'd1);
    check("ackto_dbg_fault", 32'(dbg_fault), 32'd0);
    check("ackto_dbg_rdata", dbg_rdata, 32'h1234_5678);
    step();

    // Core load alone.
    core_req = 1'b1; core_write = 1'b0; core_size = 2'd2; core_addr = 32'h100;
    step();
    check("ld_mem_addr", mem_addr, 32'h100);
    check("ld_mem_size", 32'(mem_size), 32'd2);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0; core_req = 1'b0;
    check("ld_core_done", 32'(core_done), 32'd1);
    check("ld_core_rdata", core_rdata, 32'hDEAD_BEEF);
    check("ld_core_fault", 32'(core_fault), 32'd0);
    check("ld_dbg_done", 32'(dbg_done), 32'd0);
    step();

    // Reset while BUSY, then a tie must grant core.
    dbg_req = 1'b1; dbg_addr = 32'h700;
    step();
    check("mrst_busy_addr", mem_addr, 32'h700);
    reset_n = 1'b0;
    step();
    check("mrst_mem_req", 32'(mem_req), 32'd0);
    check("mrst_mem_addr", mem_addr, 32'd0);
    check("mrst_core_rdata", core_rdata, 32'd0);
    check("mrst_dbg_rdata", dbg_rdata, 32'd0);
    check("mrst_dbg_done", 32'(dbg_done), 32'd0);
    reset_n = 1'b1;
    core_req = 1'b1; core_addr = 32'h800;
    dbg_req = 1'b1; dbg_addr = 32'h900;
    step();
    check("mrst_tie_mem_req", 32'(mem_req), 32'd1);
    check("mrst_tie_addr", mem_addr, 32'h800);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_CAFE;
    step();
    mem_ack = 1'b0; core_req = 1'b0; dbg_req = 1'b0;
    check("mrst_tie_core_done", 32'(core_done), 32'd1);
    check("mrst_tie_dbg_done", 32'(dbg_done), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single memory port between the core's load/store/fetch path and a debug/DMA requester. It sits between `core` and the memory, latches one request at a time, drives a req/ack transaction to the memory, and returns data and fault status to the winning requester. A watchdog aborts transactions the memory never acknowledges.

## Interface
- `TIMEOUT`, 255: max BUSY cycles without `mem_ack` before abort; must be ≥1.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `core_req`  in  1  core request, held until `core_done`.
- `core_write`  in  1  1 = store, 0 = load/fetch.
- `core_size`  in  2  access size code, passed through unchanged.
- `core_addr`  in  32  byte address.
- `core_wdata`  in  32  store data.
- `core_done`  out  1  one-cycle completion pulse.
- `core_rdata`  out  32  load data, valid with `core_done`.
- `core_fault`  out  2  fault code, valid with `core_done`.
- `dbg_req`, `dbg_write`, `dbg_size`, `dbg_addr`, `dbg_wdata`, `dbg_done`, `dbg_rdata`, `dbg_fault`: same as the `core_*` set, for the debug requester.
- `mem_req`  out  1  downstream request, held until ack.
- `mem_write`, `mem_size`, `mem_addr`, `mem_wdata`  out  1/2/32/32  latched request fields.
- `mem_ack`  in  1  memory completion, single cycle.
- `mem_rdata`  in  32  read data, valid with `mem_ack`.
- `mem_err`  in  1  memory access/alignment fault, valid with `mem_ack`.

## Operation
- Fault codes: 00 none, 01 `mem_err`, 10 timeout, 11 reserved (never driven).
- States: IDLE, BUSY, RESP.
- IDLE: if either `*_req` is high, pick a winner, latch `write/size/addr/wdata` and `grant`, clear the watchdog, and go to BUSY. Otherwise stay in IDLE.
- Arbitration: a single requester wins outright. On a tie, the winner is the requester not in `last_grant`. `last_grant` resets to dbg, so the core wins the first tie.
- BUSY: `mem_req`=1 with the latched fields.
  - On `mem_ack`: capture `mem_rdata`, set fault = `mem_err` ? 01 : 00, go to RESP.
  - Else, if the watchdog = `TIMEOUT`-1: rdata = 0, fault = 10, go to RESP.
  - Else: increment the watchdog.
- RESP: pulse the granted requester's `*_done` with the captured rdata/fault, set `last_grant` = grant, return to IDLE. The other requester's `done` stays 0.
- Requests are sampled only in IDLE. A `*_req` dropping or changing while BUSY/RESP is ignored; the latched transaction completes and `done` still pulses.
- A requester deasserts `req` in the cycle after `done` unless it is issuing a new request.
- Simultaneous `mem_ack` and timeout in the same cycle: ack wins.
- `mem_ack` outside BUSY is ignored.
- `*_rdata`/`*_fault` hold their last captured values outside RESP; only the cycle where `done`=1 is meaningful.

## Timing
- Reset (`reset_n`=0 at a rising edge), including mid-transaction: state = IDLE, `mem_req`=0, all `*_done`=0, `*_rdata`=0, `*_fault`=00, `mem_*` fields = 0, `last_grant` = dbg, watchdog = 0. An in-flight memory transaction is abandoned; the memory is reset by the same signal.
- Latency, with the request sampled in IDLE at cycle 0:
  - `mem_req` is high from cycle 1.
  - `mem_ack` in cycle k≥1 gives `done` in cycle k+1.
  - Back-to-back minimum: `done` at cycle 2, next IDLE sample at cycle 3.
- Timeout: with no ack, `done` with fault 10 arrives in cycle `TIMEOUT`+1.
- All outputs are registered; no combinational path from any `*_req` to `mem_*`.

## Structure
- `mem_arb_pkg`: state enum (IDLE/BUSY/RESP), fault-code constants, requester-id enum (REQ_CORE, REQ_DBG).
- Sub-module `bus_watchdog`: clear/enable counter of width `$clog2(TIMEOUT)`, `expired` flag when count = `TIMEOUT`-1.
- The round-robin pick is inline in `mem_arbiter`.

## Test plan
- Core load alone: `core_req`, addr 0x100, `mem_ack` in the first BUSY cycle with rdata 0xDEADBEEF → `core_done` in cycle 2 with rdata 0xDEADBEEF and fault 00; `dbg_done` stays 0.
- Tie after reset: both requests held for two transactions → order core then dbg; a third tie grants core.
- `mem_err` with ack → the granted requester receives fault 01.
- `TIMEOUT`=4, never ack → `done` in cycle 5 with fault 10; `mem_req` drops in the RESP cycle.
- Ack and timeout in the same cycle → fault 00 and rdata captured.
- `reset_n` low during BUSY → the next cycle shows `mem_req`=0 and state IDLE. After release, a tie grants core.
